conv_feeder: RTL
================

// Module: conv_feeder
// PURPOSE
//  Producer side of the 3x3 computing-core interface. On start, fetches one 3x3 kernel for 4 filters from weight memory.
//  Drives 9 consecutive weight_load beats (index 0..8), then streams NUM_WIN activation windows from 3 row FIFOs.
//  Sits between the weight SRAM / line-buffer FIFOs and computing_core; one run = one kernel set x one output row.
// PARAMETERS
//  WIDTH    8   data width of one weight / one pixel
//  NUM_WIN  30  windows streamed per run (1..2^CNT_W-1)
//  WADDR_W  8   weight memory address width
//  CNT_W    8   window counter width
// PORTS
//  clk              in   1          clock
//  rst              in   1          reset, synchronous, active-high
//  start            in   1          1-cycle run request; ignored while busy
//  kernel_base      in   WADDR_W    address of tap 0; taps at kernel_base+0..8; sampled on accepted start
//  hold             in   1          stall streaming (downstream back-pressure)
//  busy             out  1          high from cycle after accepted start until done
//  done             out  1          1-cycle pulse after last window issued
//  load_err         out  1          sticky: weight_load_done low on 9th load beat; cleared by rst/accepted start
//  w_rd_en          out  1          weight memory read strobe
//  w_rd_addr        out  WADDR_W    weight memory address
//  w_rd_data        in   4*WIDTH    {f3,f2,f1,f0} taps, valid 1 cycle after w_rd_en
//  ff_empty         in   3          per-row FIFO empty (FWFT FIFOs)
//  ff_dout0..2      in   3*WIDTH    head window of row FIFO 0..2
//  ff_ren           out  1          common pop of all 3 FIFOs (== activate_ready)
//  weight_load      out  1          to core: tap beat valid
//  weight0..3       out  WIDTH      to core: tap for filter 0..3 (= w_rd_data slices)
//  weight_load_done in   1          from core: high when core tap index is 7 or 8
//  activate_ready   out  1          to core: window valid (core samples when weight_load low)
//  activate0..2     out  3*WIDTH    to core: = ff_dout0..2
// BEHAVIOUR
//  Reset: state IDLE; busy, done, load_err, w_rd_en, weight_load, ff_ren, activate_ready = 0; counters 0.
//  FSM: IDLE -start-> WREQ -9 reads issued-> WLAST -> STREAM -NUM_WIN pops-> FIN -> IDLE.
//  WREQ: 9 cycles, w_rd_en=1, w_rd_addr=kernel_base+tap, tap 0..8; addr wraps mod 2^WADDR_W.
//  weight_load = w_rd_en delayed 1 cycle; weights combinational from w_rd_data. Exactly 9 contiguous beats.
//  The core tap index relies on this: no gaps, no 10th beat.
//  WLAST: the 9th weight_load beat; sample weight_load_done here; if 0, set load_err. Run continues regardless.
//  STREAM: activate_ready = ff_ren = ~hold & ~|ff_empty & (win_cnt<NUM_WIN). Combinational; never asserted with weight_load.
//  Each pop increments win_cnt; after the NUM_WIN-th pop, next cycle is FIN: done=1, busy=0 next; return to IDLE.
//  Empty/hold: stall with ready low; no timeout. Any single FIFO empty stalls all three (rows stay aligned).
//  start in FIN or while busy: ignored. start in IDLE same cycle as rst: rst wins.
//  rst mid-run: immediate return to IDLE, outputs per reset. Core is reset by same rst, so index realigns.
//  Latency: start -> first weight_load = 2 cycles; start -> first possible ready = 12 cycles.
//  Minimum run = 11 + NUM_WIN cycles with FIFOs non-empty and hold low.
// STRUCTURE
//  Shared package/header: WIDTH, KTAPS=9, NFILT=4, FSM state encodings (shared with computing_core users).
//  Single module; no sub-module needed: the FSM plus 2 counters are small. Keep the tap counter separate from win_cnt.
// TESTING
//  T1 start, kernel_base=0x10, mem[a]=a -> rd addr 0x10..0x18; weight_load high cycles 2..10; weight0 = 0x10..0x18 in order.
//  T2 NUM_WIN=4, FIFOs full, hold=0 -> ready high 4 consecutive cycles from cycle 12; done pulse cycle 16; busy falls.
//  T3 ff_empty=3'b010 for 3 cycles mid-stream -> ready low those cycles; pop count still 4; windows in FIFO order.
//  T4 hold pulse 2 cycles during STREAM -> no pop while hold; start asserted while busy -> ignored, no 2nd run.
//  T5 rst in cycle 5 of WREQ then new start -> clean 9 beats from tap 0; core weight_load_done high on 8th/9th beat; load_err=0.
//  T6 tie weight_load_done=0 -> load_err=1 after the 9th beat; stays 1 through done; cleared by the next start.

Source files
------------

// File: rtl/conv_feeder_pkg.sv
// Shared constants and FSM encoding for the 3x3 core feeder path.
// Imported by conv_feeder and by computing_core users.
package conv_feeder_pkg;

    localparam int WIDTH = 8;
    localparam int KTAPS = 9;
    localparam int NFILT = 4;
    localparam int TAP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WREQ,
        ST_WLAST,
        ST_STREAM,
        ST_FIN
    } state_e;

endpackage

// File: rtl/conv_feeder.sv
// Producer for the 3x3 computing core: loads one 4-filter kernel,
// then streams NUM_WIN aligned windows from the three row FIFOs.
module conv_feeder #(
    parameter int WIDTH   = conv_feeder_pkg::WIDTH,
    parameter int NUM_WIN = 30,
    parameter int WADDR_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [WADDR_W-1:0]                     kernel_base,
    input  logic                                   hold,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   load_err,
    output logic                                   w_rd_en,
    output logic [WADDR_W-1:0]                     w_rd_addr,
    input  logic [conv_feeder_pkg::NFILT*WIDTH-1:0] w_rd_data,
    input  logic [2:0]                             ff_empty,
    input  logic [3*WIDTH-1:0]                     ff_dout0,
    input  logic [3*WIDTH-1:0]                     ff_dout1,
    input  logic [3*WIDTH-1:0]                     ff_dout2,
    output logic                                   ff_ren,
    output logic                                   weight_load,
    output logic [WIDTH-1:0]                       weight0,
    output logic [WIDTH-1:0]                       weight1,
    output logic [WIDTH-1:0]                       weight2,
    output logic [WIDTH-1:0]                       weight3,
    input  logic                                   weight_load_done,
    output logic                                   activate_ready,
    output logic [3*WIDTH-1:0]                     activate0,
    output logic [3*WIDTH-1:0]                     activate1,
    output logic [3*WIDTH-1:0]                     activate2
);

    import conv_feeder_pkg::*;

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [WADDR_W-1:0] base_q, base_d;
    logic               err_q, err_d;
    logic               wl_q;
    logic               go;
    logic               pop;

    assign go  = (state_q == ST_IDLE) & start;
    assign pop = (state_q == ST_STREAM) & ~hold & ~|ff_empty
               & (win_q < CNT_W'(NUM_WIN));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // WLAST spans the 9th beat plus one guard cycle before windows
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_WREQ;
            ST_WREQ:   if (tap_q == TAP_W'(KTAPS-1)) state_d = ST_WLAST;
            ST_WLAST:  if (tap_q == TAP_W'(KTAPS+1)) state_d = ST_STREAM;
            ST_STREAM: if (pop && win_q == CNT_W'(NUM_WIN-1)) state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_rd_en = 1'b0;
        unique case (state_q)
            ST_WREQ: begin
                busy    = 1'b1;
                w_rd_en = 1'b1;
            end
            ST_WLAST, ST_STREAM: busy = 1'b1;
            ST_FIN:              done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        tap_d  = tap_q;
        win_d  = win_q;
        base_d = base_q;
        err_d  = err_q;
        if (go) begin
            tap_d  = '0;
            win_d  = '0;
            base_d = kernel_base;
            err_d  = 1'b0;
        end else begin
            if (state_q == ST_WREQ || state_q == ST_WLAST)
                tap_d = tap_q + 1'b1;
            if (pop)
                win_d = win_q + 1'b1;
            if (state_q == ST_WLAST && tap_q == TAP_W'(KTAPS) && !weight_load_done)
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q  <= '0;
            win_q  <= '0;
            base_q <= '0;
            err_q  <= 1'b0;
            wl_q   <= 1'b0;
        end else begin
            tap_q  <= tap_d;
            win_q  <= win_d;
            base_q <= base_d;
            err_q  <= err_d;
            wl_q   <= (state_q == ST_WREQ);
        end
    end

    assign w_rd_addr      = base_q + WADDR_W'(tap_q);
    assign load_err       = err_q;
    assign weight_load    = wl_q;
    assign weight0        = w_rd_data[0*WIDTH +: WIDTH];
    assign weight1        = w_rd_data[1*WIDTH +: WIDTH];
    assign weight2        = w_rd_data[2*WIDTH +: WIDTH];
    assign weight3        = w_rd_data[3*WIDTH +: WIDTH];
    assign ff_ren         = pop;
    assign activate_ready = pop;
    assign activate0      = ff_dout0;
    assign activate1      = ff_dout1;
    assign activate2      = ff_dout2;

endmodule
